// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: the sequencer raises a request with a
// byte address and holds it until memory acks with the instruction word.
interface pc_sequencer_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;

    // Sequencer side: issues requests, receives ack/data.
    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_ack,
        input  i_imem_data
    );

    // Memory side: receives requests, returns ack/data.
    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_ack,
        output i_imem_data
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/PC controller. Owns the PC, fetches one instruction
// at a time over the imem handshake, hands it to decode, then waits for
// the branch/jump decision before loading the next PC.
module pc_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    pc_sequencer_if.master        imem,
    output logic [31:0]           o_instr,
    output logic                  o_instr_valid,
    input  logic                  i_resolve,
    input  logic                  i_stall,
    input  logic                  i_pc_src,
    input  logic [29:0]           i_target_pc,
    output logic [29:0]           o_incr_pc,
    output logic [29:0]           o_pc,
    output logic [31:0]           o_retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic [29:0] pc_q, pc_nxt;
    logic [31:0] ret_q, ret_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        valid_q, valid_nxt;

    // Fetch port and incrementer depend only on registered state, so there
    // is no combinational path from the ack back to the request.
    assign o_incr_pc        = pc_q + 30'd1;
    assign o_pc             = pc_q;
    assign o_retired        = ret_q;
    assign o_instr          = instr_q;
    assign o_instr_valid    = valid_q;
    assign imem.o_imem_req  = (state == S_FETCH);
    assign imem.o_imem_addr = {pc_q, 2'b00};

    // State and datapath registers; reset wins over everything, even mid-fetch.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            ret_q   <= 32'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            ret_q   <= ret_nxt;
            instr_q <= instr_nxt;
            valid_q <= valid_nxt;
        end
    end

    // Next-state and datapath selection; valid is a one-cycle pulse so it
    // defaults low, and ack/resolve only matter in their own states.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ret_nxt   = ret_q;
        instr_nxt = instr_q;
        valid_nxt = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem.i_imem_ack) begin
                    instr_nxt = imem.i_imem_data;
                    valid_nxt = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (i_resolve && !i_stall) begin
                    pc_nxt    = i_pc_src ? i_target_pc : o_incr_pc;
                    ret_nxt   = ret_q + 32'd1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Stimulus pushes expected fetch starts
// and expected instructions into queues; a negedge monitor pops and checks
// them whenever the DUT starts a fetch or pulses o_instr_valid.
module tb_pc_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_resolve, i_stall, i_pc_src;
    logic [29:0] i_target_pc;
    logic [29:0] o_incr_pc, o_pc;
    logic [31:0] o_retired;

    pc_sequencer_if imem_if ();

    pc_sequencer #(.RESET_PC(30'h100)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .imem         (imem_if),
        .o_instr      (o_instr),
        .o_instr_valid(o_instr_valid),
        .i_resolve    (i_resolve),
        .i_stall      (i_stall),
        .i_pc_src     (i_pc_src),
        .i_target_pc  (i_target_pc),
        .o_incr_pc    (o_incr_pc),
        .o_pc         (o_pc),
        .o_retired    (o_retired)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ret;
        int          cyc;
    } fetch_t;

    fetch_t      fq[$];
    logic [31:0] iq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        req_prev = 1'b0;
    logic [29:0] cur_pc;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: a rising o_imem_req marks the start of a fetch; check its
    // address, retire count and the cycle on which it appeared.
    always @(negedge i_clk) begin
        fetch_t f;
        logic [31:0] ei;
        if (imem_if.o_imem_req === 1'b1 && req_prev !== 1'b1) begin
            if (fq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL fetch_unexpected: addr %h with no expected fetch", imem_if.o_imem_addr);
            end else begin
                f = fq.pop_front();
                chk("fetch_addr", imem_if.o_imem_addr, f.addr);
                chk("fetch_retired", o_retired, f.ret);
                chk("fetch_cycle", cyc, f.cyc);
            end
        end
        if (o_instr_valid === 1'b1) begin
            if (iq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL instr_valid_unexpected: instr %h with no expected pulse", o_instr);
            end else begin
                ei = iq.pop_front();
                chk("instr", o_instr, ei);
            end
        end
        req_prev = imem_if.o_imem_req;
    end

    // One instruction from the current FETCH: optional ack waits, ack,
    // optional stalls (with junk redirect inputs), then the resolving edge.
    task automatic do_instr(input logic [31:0] data, input int waits, input int stalls,
                            input logic src, input logic [29:0] tgt,
                            input logic [29:0] exp_pc, input logic [31:0] exp_ret);
        logic [29:0] exp_inc;
        for (int k = 0; k < waits; k++) begin
            tick();
            chk("wait_req", {31'd0, imem_if.o_imem_req}, 32'd1);
            chk("wait_addr", imem_if.o_imem_addr, {cur_pc, 2'b00});
        end
        imem_if.i_imem_ack  = 1'b1;
        imem_if.i_imem_data = data;
        iq.push_back(data);
        tick();
        imem_if.i_imem_ack  = 1'b0;
        imem_if.i_imem_data = 32'h0BAD_0BAD;
        i_resolve = 1'b1;
        for (int k = 0; k < stalls; k++) begin
            i_stall     = 1'b1;
            i_pc_src    = ~src;
            i_target_pc = 30'h123_4567;
            tick();
            chk("stall_pc", {2'b00, o_pc}, {2'b00, cur_pc});
            chk("stall_req", {31'd0, imem_if.o_imem_req}, 32'd0);
        end
        i_stall     = 1'b0;
        i_pc_src    = src;
        i_target_pc = tgt;
        fq.push_back('{addr: {exp_pc, 2'b00}, ret: exp_ret, cyc: cyc + 1});
        tick();
        i_resolve   = 1'b0;
        i_pc_src    = 1'b0;
        i_target_pc = 30'h0;
        exp_inc = exp_pc + 30'd1;
        chk("resolved_pc", {2'b00, o_pc}, {2'b00, exp_pc});
        chk("resolved_incr", {2'b00, o_incr_pc}, {2'b00, exp_inc});
        cur_pc = exp_pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_resolve = 1'b0; i_stall = 1'b0; i_pc_src = 1'b0; i_target_pc = 30'h0;
        imem_if.i_imem_ack = 1'b0; imem_if.i_imem_data = 32'h0;
        cur_pc = 30'h100;
        repeat (3) tick();

        // Reset state
        chk("rst_req", {31'd0, imem_if.o_imem_req}, 32'd0);
        chk("rst_pc", {2'b00, o_pc}, 32'h100);
        chk("rst_incr", {2'b00, o_incr_pc}, 32'h101);
        chk("rst_retired", o_retired, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);

        // Release: one IDLE cycle, then fetch of 0x400
        i_rst_n = 1'b1;
        fq.push_back('{addr: 32'h400, ret: 32'd0, cyc: cyc + 1});
        tick();
        chk("first_req", {31'd0, imem_if.o_imem_req}, 32'd1);

        //        data          waits stalls src  target         next pc        retired
        do_instr(32'h2008_0005, 0, 0, 1'b0, 30'h0,         30'h101,       32'd1);
        do_instr(32'h1111_1111, 0, 0, 1'b1, 30'h0F0,       30'h0F0,       32'd2);
        do_instr(32'h2222_2222, 4, 2, 1'b0, 30'h0,         30'h0F1,       32'd3);
        do_instr(32'h3333_3333, 1, 0, 1'b1, 30'h3FFF_FFFF, 30'h3FFF_FFFF, 32'd4);
        do_instr(32'h4444_4444, 0, 1, 1'b0, 30'h0,         30'h0,         32'd5);
        do_instr(32'h5555_5555, 0, 0, 1'b1, 30'h0AB,       30'h0AB,       32'd6);

        // Resolve during FETCH is ignored
        i_resolve = 1'b1; i_pc_src = 1'b1; i_target_pc = 30'h3;
        tick();
        i_resolve = 1'b0; i_pc_src = 1'b0; i_target_pc = 30'h0;
        chk("spur_resolve_pc", {2'b00, o_pc}, 32'h0AB);
        chk("spur_resolve_req", {31'd0, imem_if.o_imem_req}, 32'd1);

        // Ack during EXEC is ignored
        imem_if.i_imem_ack = 1'b1; imem_if.i_imem_data = 32'h6666_6666;
        iq.push_back(32'h6666_6666);
        tick();
        imem_if.i_imem_data = 32'hDEAD_BEEF;
        repeat (2) tick();
        imem_if.i_imem_ack = 1'b0;
        chk("spur_ack_instr", o_instr, 32'h6666_6666);
        chk("spur_ack_req", {31'd0, imem_if.o_imem_req}, 32'd0);
        chk("spur_ack_valid", {31'd0, o_instr_valid}, 32'd0);
        i_resolve = 1'b1;
        fq.push_back('{addr: 32'h2B0, ret: 32'd7, cyc: cyc + 1});
        tick();
        i_resolve = 1'b0;
        chk("post_spur_pc", {2'b00, o_pc}, 32'h0AC);

        // Reset in the middle of a fetch
        chk("midrst_req_before", {31'd0, imem_if.o_imem_req}, 32'd1);
        i_rst_n = 1'b0;
        tick();
        chk("midrst_req", {31'd0, imem_if.o_imem_req}, 32'd0);
        chk("midrst_pc", {2'b00, o_pc}, 32'h100);
        chk("midrst_retired", o_retired, 32'd0);
        chk("midrst_instr", o_instr, 32'd0);
        i_rst_n = 1'b1;
        fq.push_back('{addr: 32'h400, ret: 32'd0, cyc: cyc + 1});
        tick();
        imem_if.i_imem_ack = 1'b1; imem_if.i_imem_data = 32'h7777_7777;
        iq.push_back(32'h7777_7777);
        tick();
        imem_if.i_imem_ack = 1'b0;
        repeat (3) tick();

        chk("fetch_queue_drained", fq.size(), 32'd0);
        chk("instr_queue_drained", iq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
